// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the pattern sequencer.
//   seq_state_t : sequencer FSM state encoding
//   MIN_DIV     : shortest legal step period in clock cycles (FETCH, CAPTURE, one WAIT)
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        WAIT
    } seq_state_t;

    localparam int unsigned MIN_DIV = 3;

endpackage

// File: rtl/tempo_divider.sv
// tempo_divider: step-period down-counter for the pattern sequencer.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset, clears the count
//   load   : load the counter from div (asserted in the FETCH cycle)
//   clear  : force the count to zero (asserted while idle)
//   div    : requested step period in cycles; values below MIN_DIV clamp to MIN_DIV
//   expire : high in the last cycle of the step period
module tempo_divider
    import seq_pkg::*;
#(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             expire
);

    localparam logic [DIV_W-1:0] MinDiv = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] One    = DIV_W'(1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Load happens in the FETCH cycle itself, so the count is loaded with period-1;
    // reaching 1 then lands exactly one cycle before the next FETCH.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (div < MinDiv) ? (MinDiv - One) : (div - One);
        end else if (count_q != '0) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == One);

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: steps through a looped pattern stored in RAM at a programmable tempo.
// Ports:
//   CLK          : system clock
//   RESET        : synchronous active-low reset
//   RUN          : level, high = sequence, low = stop
//   base_addr    : first pattern word address (sampled when entering FETCH)
//   step_count   : steps per loop, 0 means 256 (sampled when entering FETCH)
//   tempo_div    : clock cycles per step, clamped to at least 3 (sampled in FETCH)
//   INT_ADDR     : registered RAM read address, valid throughout FETCH
//   INT_READDATA : RAM read data, valid the cycle after INT_ADDR
//   step_data    : registered pattern word of the current step
//   step_valid   : one-cycle pulse when step_data updates
//   step_index   : index of the step held in step_data
//   busy         : high whenever the FSM is not idle
module pattern_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIV_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RUN,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        step_count,
    input  logic [DIV_W-1:0]  tempo_div,
    output logic [ADDR_W-1:0] INT_ADDR,
    input  logic [DATA_W-1:0] INT_READDATA,
    output logic [DATA_W-1:0] step_data,
    output logic              step_valid,
    output logic [7:0]        step_index,
    output logic              busy
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [7:0]        idx_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] int_addr_q;
    logic [DATA_W-1:0] step_data_q;
    logic              step_valid_q;
    logic [7:0]        step_index_q;

    logic       expire;
    logic       capture;
    logic [8:0] idx_inc;
    logic [8:0] eff_count;
    logic [7:0] idx_next;

    // Next-state logic; RUN low always returns to IDLE on the following edge.
    always_comb begin
        state_d = state_q;
        if (!RUN) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = CAPTURE;
                CAPTURE: state_d = WAIT;
                WAIT:    state_d = expire ? FETCH : WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // A capture that coincides with RUN low is abandoned: no load, no pulse.
    assign capture = (state_q == CAPTURE) && RUN;

    // Step counter wrap; >= keeps idx in range if step_count shrinks mid-loop.
    always_comb begin
        idx_inc   = {1'b0, idx_q} + 9'd1;
        eff_count = (cnt_q == 8'd0) ? 9'd256 : {1'b0, cnt_q};
        idx_next  = (idx_inc >= eff_count) ? 8'd0 : idx_inc[7:0];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            idx_q        <= 8'd0;
            cnt_q        <= 8'd0;
            int_addr_q   <= '0;
            step_data_q  <= '0;
            step_valid_q <= 1'b0;
            step_index_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            step_valid_q <= capture;

            if (state_d == IDLE) begin
                idx_q <= 8'd0;
            end else if (capture) begin
                idx_q <= idx_next;
            end

            // Address is registered on entry so it is stable for the whole FETCH cycle.
            if (state_d == FETCH) begin
                int_addr_q <= base_addr + ADDR_W'(idx_q);
                cnt_q      <= step_count;
            end

            if (capture) begin
                step_data_q  <= INT_READDATA;
                step_index_q <= idx_q;
            end
        end
    end

    tempo_divider #(
        .DIV_W (DIV_W)
    ) u_tempo_divider (
        .clk    (CLK),
        .rst_n  (RESET),
        .load   (state_q == FETCH),
        .clear  (state_q == IDLE),
        .div    (tempo_div),
        .expire (expire)
    );

    assign INT_ADDR   = int_addr_q;
    assign step_data  = step_data_q;
    assign step_valid = step_valid_q;
    assign step_index = step_index_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: self-checking bench for pattern_sequencer.
// A RAM model returns a known word per address; expected steps are queued when a run
// is started and checked against each step_valid pulse (address, index, data, spacing).
module tb_pattern_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RUN;
    logic [11:0] base_addr;
    logic [7:0]  step_count;
    logic [31:0] tempo_div;
    logic [11:0] INT_ADDR;
    logic [31:0] INT_READDATA;
    logic [31:0] step_data;
    logic        step_valid;
    logic [7:0]  step_index;
    logic        busy;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  idx;
        logic [31:0] data;
        int          gap;
        bit          first;
    } exp_t;

    typedef struct {
        logic [11:0] base;
        logic [7:0]  count;
        logic [31:0] div;
        int          nsteps;
        int          period;  // expected FETCH-to-FETCH cycles
        int          eff;     // expected steps per loop
    } vec_t;

    exp_t sb[$];
    vec_t vt[6];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_cyc = 0;

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {8'h5A, 4'h0, a, ~a[7:0]};
    endfunction

    // One-cycle-latency RAM model.
    always @(posedge CLK) INT_READDATA <= pat(INT_ADDR);

    pattern_sequencer #(
        .ADDR_W (12),
        .DATA_W (32),
        .DIV_W  (32)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RUN          (RUN),
        .base_addr    (base_addr),
        .step_count   (step_count),
        .tempo_div    (tempo_div),
        .INT_ADDR     (INT_ADDR),
        .INT_READDATA (INT_READDATA),
        .step_data    (step_data),
        .step_valid   (step_valid),
        .step_index   (step_index),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [7:0] ix, input int gap,
                        input bit first);
        exp_t e;
        e.addr  = a;
        e.idx   = ix;
        e.data  = pat(a);
        e.gap   = gap;
        e.first = first;
        sb.push_back(e);
    endtask

    // Returns at negedge+1 once every queued step has been seen, or flags a timeout.
    task automatic drain(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(negedge CLK);
            #1;
            c++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_int_addr"}, INT_ADDR, 0);
        chk({tag, "_step_data"}, step_data, 0);
        chk({tag, "_step_valid"}, step_valid, 0);
        chk({tag, "_step_index"}, step_index, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic stop_run();
        RUN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("stop_busy", busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        int          ix;

        vt[0] = '{base: 12'h010, count: 8'd4, div: 32'd10, nsteps: 5,   period: 10, eff: 4};
        vt[1] = '{base: 12'h020, count: 8'd3, div: 32'd0,  nsteps: 4,   period: 3,  eff: 3};
        vt[2] = '{base: 12'h030, count: 8'd2, div: 32'd1,  nsteps: 4,   period: 3,  eff: 2};
        vt[3] = '{base: 12'hFFE, count: 8'd4, div: 32'd5,  nsteps: 5,   period: 5,  eff: 4};
        vt[4] = '{base: 12'h100, count: 8'd1, div: 32'd2,  nsteps: 3,   period: 3,  eff: 1};
        vt[5] = '{base: 12'h000, count: 8'd0, div: 32'd3,  nsteps: 258, period: 3,  eff: 256};

        RESET      = 1'b0;
        RUN        = 1'b1;
        base_addr  = 12'h0AB;
        step_count = 8'd4;
        tempo_div  = 32'd5;

        // Step monitor: every step_valid must match the next queued expectation.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge CLK);
                    if (step_valid === 1'b1) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_step_valid: got=1 want=0 idx=%0d cycle %0d",
                                     step_index, cyc);
                        end else begin
                            e = sb.pop_front();
                            chk("step_addr", INT_ADDR, e.addr);
                            chk("step_index", step_index, e.idx);
                            chk("step_data", step_data, e.data);
                            chk("step_gap", cyc - (e.first ? start_cyc : last_cyc), e.gap);
                        end
                        last_cyc = cyc;
                    end
                end
            end
        join_none

        // Reset overrides RUN.
        repeat (3) @(negedge CLK);
        check_zero("reset");
        RUN = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("post_reset_valid", step_valid, 0);
        chk("post_reset_busy", busy, 0);

        // Table-driven runs.
        for (int i = 0; i < 6; i++) begin
            base_addr  = vt[i].base;
            step_count = vt[i].count;
            tempo_div  = vt[i].div;
            for (int k = 0; k < vt[i].nsteps; k++) begin
                ix = k % vt[i].eff;
                a  = vt[i].base + 12'(ix);
                push(a, 8'(ix), (k == 0) ? 3 : vt[i].period, k == 0);
            end
            start_cyc = cyc;
            RUN = 1'b1;
            drain(vt[i].nsteps * vt[i].period + 20);
            stop_run();
        end

        // Inputs changed mid-run apply from the next step onward.
        base_addr  = 12'h040;
        step_count = 8'd8;
        tempo_div  = 32'd4;
        push(12'h040, 8'd0, 3, 1'b1);
        start_cyc = cyc;
        RUN = 1'b1;
        drain(20);
        base_addr = 12'h050;
        tempo_div = 32'd6;
        push(12'h051, 8'd1, 4, 1'b0);
        push(12'h052, 8'd2, 6, 1'b0);
        drain(30);
        stop_run();

        // RUN dropped during CAPTURE: word discarded, restart from step 0.
        base_addr  = 12'h200;
        step_count = 8'd4;
        tempo_div  = 32'd5;
        push(12'h200, 8'd0, 3, 1'b1);
        start_cyc = cyc;
        RUN = 1'b1;
        drain(20);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("capture_int_addr", INT_ADDR, 12'h201);
        RUN = 1'b0;
        @(negedge CLK);
        chk("abort_busy", busy, 0);
        chk("abort_valid", step_valid, 0);
        chk("abort_data_held", step_data, pat(12'h200));
        chk("abort_index_held", step_index, 0);
        repeat (2) @(negedge CLK);
        push(12'h200, 8'd0, 3, 1'b1);
        start_cyc = cyc;
        RUN = 1'b1;
        drain(20);
        stop_run();

        // Reset in WAIT at step 2, then resume from step 0 with RUN held high.
        base_addr  = 12'h300;
        step_count = 8'd4;
        tempo_div  = 32'd8;
        push(12'h300, 8'd0, 3, 1'b1);
        push(12'h301, 8'd1, 8, 1'b0);
        push(12'h302, 8'd2, 8, 1'b0);
        start_cyc = cyc;
        RUN = 1'b1;
        drain(40);
        RESET = 1'b0;
        @(negedge CLK);
        check_zero("wait_reset");
        push(12'h300, 8'd0, 3, 1'b1);
        push(12'h301, 8'd1, 8, 1'b0);
        start_cyc = cyc;
        RESET = 1'b1;
        drain(30);
        stop_run();

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 12, meaning pattern RAM word-address width.
REQ-002 The block SHALL expose parameter DATA_W, default 32, meaning pattern RAM word width.
REQ-003 The block SHALL expose parameter DIV_W, default 32, meaning tempo divider width.
REQ-004 CLK  input  1  system clock, 50 MHz; the only clock in the block.
REQ-005 RESET  input  1  reset, synchronous and active-low.
REQ-006 RUN  input  1  level; high = sequence, low = stop.
REQ-007 base_addr  input  ADDR_W  first pattern word address.
REQ-008 step_count  input  8  steps per loop; 0 means 256.
REQ-009 tempo_div  input  DIV_W  clock cycles per step.
REQ-010 INT_ADDR  output  ADDR_W  registered read address to the RAM internal port.
REQ-011 INT_READDATA  input  DATA_W  RAM internal-port read data, valid the cycle after INT_ADDR is presented.
REQ-012 step_data  output  DATA_W  registered pattern word of the current step.
REQ-013 step_valid  output  1  one-cycle pulse when step_data updates.
REQ-014 step_index  output  8  index of the step held in step_data.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, CAPTURE, WAIT.
REQ-017 IDLE->FETCH when RUN=1; FETCH->CAPTURE unconditionally; CAPTURE->WAIT unconditionally; WAIT->FETCH when the tempo count expires; any state->IDLE in the cycle after RUN is sampled 0.
REQ-018 In FETCH, INT_ADDR SHALL equal (base_addr + idx) mod 2^ADDR_W, where idx is the internal step counter.
REQ-019 In CAPTURE, step_data SHALL load INT_READDATA, step_index SHALL load idx, and step_valid SHALL be 1 in the following cycle only.
REQ-020 The step period SHALL be max(tempo_div, 3) cycles, measured FETCH to FETCH; tempo_div values 0, 1 and 2 SHALL clamp to 3.
REQ-021 The first FETCH SHALL occur in the cycle after RUN is first sampled high in IDLE.
REQ-022 idx SHALL increment after each CAPTURE and wrap to 0 when it reaches the effective step count (step_count, or 256 when step_count=0).
REQ-023 base_addr, step_count and tempo_div SHALL be sampled at each FETCH; changes take effect on the next step.
REQ-024 If RUN falls during FETCH or CAPTURE, the pending word SHALL be discarded, no step_valid SHALL pulse, and step_data SHALL hold its last value.
REQ-025 Entering IDLE SHALL clear idx to 0, so the next run starts at step 0.
REQ-026 INT_ADDR wrap-around SHALL be silent modulo 2^ADDR_W, and the block SHALL NOT skip any address.

Reset
REQ-027 While RESET=0 at a clock edge, the block SHALL enter IDLE and set INT_ADDR=0, step_data=0, step_valid=0, step_index=0, busy=0, idx=0 and the tempo count to 0.
REQ-028 Reset SHALL override RUN and any in-flight fetch, with no step_valid pulse in the cycle after reset releases.

Structure
REQ-029 Package seq_pkg SHALL hold the state enum type seq_state_t and the constant MIN_DIV=3.
REQ-030 A sub-module tempo_divider SHALL implement the DIV_W down-counter with load/clamp inputs and an expire pulse output.
REQ-031 The block SHALL have no combinational path from any input to INT_ADDR, step_data, step_valid or step_index.

Verification
REQ-032 base_addr=0x010, step_count=4, tempo_div=10, RUN=1 with a RAM model -> INT_ADDR 0x010,0x011,0x012,0x013,0x010 at FETCH cycles 10 clocks apart, and step_valid 2 cycles after each FETCH with step_index 0,1,2,3,0.
REQ-033 tempo_div=0 and then 1 -> step_valid pulses every 3 cycles.
REQ-034 base_addr=0xFFE, step_count=4 -> INT_ADDR 0xFFE,0xFFF,0x000,0x001.
REQ-035 RUN dropped in a CAPTURE cycle -> no step_valid, step_data unchanged, busy=0 within 1 cycle; RUN re-raised -> restart at INT_ADDR=base_addr with step_index=0.
REQ-036 RESET=0 asserted in WAIT at step 2 -> all outputs 0 on the next cycle; after release with RUN held high, the sequence resumes from step 0.
REQ-037 step_count=0, tempo_div=3 -> 256 distinct addresses before idx wraps to 0.
